// File: rtl/mixer_ctrl_seq_if.sv
// mixer_ctrl_seq_if: native CPU bus (valid/address/wdata/wstrb -> rdata/ready) for the mixer controller
interface mixer_ctrl_seq_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32
);
   logic              valid;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic              wstrb;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   modport master (output valid, address, wdata, wstrb, input rdata, ready);
   modport slave (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/mixer_ctrl_seq.sv
// mixer_ctrl_seq: CPU-programmable pd/ota/buff power sequencer for N_CH mixer channels; MIXER_CTRL_IRQ_EN adds irq
module mixer_ctrl_seq #(
   parameter int N_CH     = 2,
   parameter int BUFF_W   = 2,
   parameter int SETTLE_W = 8,
   parameter int ADDR_W   = 2,
   parameter int DATA_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   mixer_ctrl_seq_if.slave        bus,
   output logic [N_CH-1:0]        pd,
   output logic [N_CH-1:0]        ota,
   output logic [N_CH*BUFF_W-1:0] buff
`ifdef MIXER_CTRL_IRQ_EN
   ,
   output logic                   irq
`endif
);
   typedef enum logic [2:0] {IDLE, STEP1, WAIT1, STEP2, WAIT2, STEP3} state_t;
   state_t state, state_n;
   logic [N_CH-1:0] en_tgt, en_cur, up, dn, dn_act;
   logic [BUFF_W-1:0] buff_cfg, buff_d;
   logic [SETTLE_W-1:0] settle, counter;
   logic [DATA_W-1:0] rd_mux;
   logic done, busy, wr;
   assign busy = state != IDLE;
   assign dn_act = busy ? dn : '0;
   assign wr = bus.valid && bus.wstrb;
`ifdef MIXER_CTRL_IRQ_EN
   logic irq_en;
   logic [N_CH:0] ctrl_rd;
   assign ctrl_rd = {irq_en, en_tgt};
   assign irq = done && irq_en;
`else
   logic [N_CH-1:0] ctrl_rd;
   assign ctrl_rd = en_tgt;
`endif
   // register read view
   always_comb
      rd_mux = bus.address == ADDR_W'(0) ? DATA_W'(ctrl_rd) :
               bus.address == ADDR_W'(1) ? DATA_W'(buff_cfg) :
               bus.address == ADDR_W'(2) ? DATA_W'(settle) :
               DATA_W'({en_cur, done, busy});
   // one-cycle acknowledge, registered read data and CPU-writable registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.ready <= 1'b0;
         bus.rdata <= '0;
         en_tgt    <= '0;
         buff_cfg  <= '0;
         buff_d    <= '0;
         settle    <= '0;
`ifdef MIXER_CTRL_IRQ_EN
         irq_en    <= 1'b0;
`endif
      end else begin
         bus.ready <= bus.valid;
         if (bus.valid && !bus.wstrb) bus.rdata <= rd_mux;
         if (wr && bus.address == ADDR_W'(0)) en_tgt <= bus.wdata[N_CH-1:0];
`ifdef MIXER_CTRL_IRQ_EN
         if (wr && bus.address == ADDR_W'(0)) irq_en <= bus.wdata[N_CH];
`endif
         if (wr && bus.address == ADDR_W'(1)) buff_cfg <= bus.wdata[BUFF_W-1:0];
         if (wr && bus.address == ADDR_W'(2)) settle <= bus.wdata[SETTLE_W-1:0];
         buff_d <= buff_cfg;
      end
   // sequencer state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   // step order; a zero settle skips the wait state so steps land on consecutive edges
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = en_tgt != en_cur ? STEP1 : IDLE;
         STEP1:   state_n = settle == '0 ? STEP2 : WAIT1;
         WAIT1:   state_n = counter == '0 ? STEP2 : WAIT1;
         STEP2:   state_n = settle == '0 ? STEP3 : WAIT2;
         WAIT2:   state_n = counter == '0 ? STEP3 : WAIT2;
         STEP3:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // channel outputs, latched masks, settle counter and completion flag
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         up      <= '0;
         dn      <= '0;
         en_cur  <= '0;
         counter <= '0;
         done    <= 1'b0;
         pd      <= '1;
         ota     <= '0;
         buff    <= '0;
      end else begin
         if (state == IDLE) begin
            up <= en_tgt & ~en_cur;
            dn <= en_cur & ~en_tgt;
         end
         counter <= state == STEP1 || state == STEP2 ? settle - SETTLE_W'(1) :
                    (state == WAIT1 || state == WAIT2) && counter != '0 ? counter - SETTLE_W'(1) : counter;
         pd <= state == STEP1 ? pd & ~up : state == STEP3 ? pd | dn : pd;
         ota <= state == STEP2 ? (ota | up) & ~dn : ota;
         en_cur <= state == STEP3 ? (en_cur | up) & ~dn : en_cur;
         done <= state == STEP3 ? 1'b1 : wr && bus.address == ADDR_W'(3) ? 1'b0 : done;
         for (int i = 0; i < N_CH; i++)
            buff[i*BUFF_W +: BUFF_W] <= state == STEP1 && dn[i] ? '0 :
                                        state == STEP3 && up[i] ? buff_cfg :
                                        en_cur[i] && !dn_act[i] ? buff_d : buff[i*BUFF_W +: BUFF_W];
      end
endmodule

// File: tb/tb_mixer_ctrl_seq.sv
// tb_mixer_ctrl_seq: table, directed and randomized checks of mixer_ctrl_seq against a step-timing model
module tb_mixer_ctrl_seq;
   localparam int N_CH = 2, BUFF_W = 2, SETTLE_W = 8, ADDR_W = 2, DATA_W = 32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N_CH-1:0] pd, ota;
   logic [N_CH*BUFF_W-1:0] buff;
`ifdef MIXER_CTRL_IRQ_EN
   logic irq;
`endif
   int applied = 0, miscompares = 0;
   mixer_ctrl_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   mixer_ctrl_seq #(.N_CH(N_CH), .BUFF_W(BUFF_W), .SETTLE_W(SETTLE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .pd(pd), .ota(ota), .buff(buff)
`ifdef MIXER_CTRL_IRQ_EN
      , .irq(irq)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {
      logic v, w;
      logic [1:0] a;
      logic [31:0] d;
      logic rdy;
      logic [31:0] rd;
      logic [1:0] pd, ota;
      logic [3:0] buff;
   } vec_t;
   vec_t tbl [19];
   // model: channel state plus the number of edges since a sequence was latched
   logic [N_CH-1:0] m_tgt, m_cur, m_up, m_dn, m_pd, m_ota;
   logic [BUFF_W-1:0] m_buff [N_CH];
   logic [BUFF_W-1:0] m_cfg, m_cfg_d;
   logic [SETTLE_W-1:0] m_settle;
   logic [31:0] m_rdata;
   logic m_done, m_irq_en, m_ready, m_rdv;
   int m_k;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic model_reset();
      m_tgt = '0; m_cur = '0; m_up = '0; m_dn = '0; m_pd = '1; m_ota = '0;
      for (int i = 0; i < N_CH; i++) m_buff[i] = '0;
      m_cfg = '0; m_cfg_d = '0; m_settle = '0; m_rdata = '0;
      m_done = 1'b0; m_irq_en = 1'b0; m_ready = 1'b0; m_rdv = 1'b0; m_k = -1;
   endtask
   task automatic model_edge(input logic v, input logic w, input logic [1:0] a, input logic [31:0] d);
      logic busy0, s1, s2, s3;
      logic [BUFF_W-1:0] cfg0;
      logic [31:0] rd;
      int s;
      busy0 = m_k >= 0;
      s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
      s = int'(m_settle);
      cfg0 = m_cfg;
      rd = a == 2'd0 ? 32'(m_tgt) | (32'(m_irq_en) << N_CH) : a == 2'd1 ? 32'(m_cfg) :
           a == 2'd2 ? 32'(m_settle) : (32'(m_cur) << 2) | (32'(m_done) << 1) | 32'(busy0);
`ifndef MIXER_CTRL_IRQ_EN
      if (a == 2'd0) rd = 32'(m_tgt);
`endif
      if (!busy0) begin
         if (m_tgt != m_cur) begin
            m_up = m_tgt & ~m_cur;
            m_dn = m_cur & ~m_tgt;
            m_k = 0;
         end
      end else begin
         m_k++;
         s1 = m_k == 1;
         s2 = m_k == 2 + s;
         s3 = m_k == 3 + 2 * s;
      end
      for (int i = 0; i < N_CH; i++)
         if (s1 && m_dn[i]) m_buff[i] = '0;
         else if (s3 && m_up[i]) m_buff[i] = cfg0;
         else if (m_cur[i] && !(busy0 && m_dn[i])) m_buff[i] = m_cfg_d;
      if (s1) m_pd = m_pd & ~m_up;
      if (s2) m_ota = (m_ota | m_up) & ~m_dn;
      if (v && w && a == 2'd3) m_done = 1'b0;
      if (s3) begin
         m_pd = m_pd | m_dn;
         m_cur = (m_cur | m_up) & ~m_dn;
         m_done = 1'b1;
         m_k = -1;
      end
      if (v && w && a == 2'd0) m_tgt = d[N_CH-1:0];
`ifdef MIXER_CTRL_IRQ_EN
      if (v && w && a == 2'd0) m_irq_en = d[N_CH];
`endif
      if (v && w && a == 2'd1) m_cfg = d[BUFF_W-1:0];
      if (v && w && a == 2'd2) m_settle = d[SETTLE_W-1:0];
      m_cfg_d = cfg0;
      m_ready = v;
      m_rdv = v && !w;
      if (m_rdv) m_rdata = rd;
   endtask
   task automatic cmp_model();
      logic [N_CH*BUFF_W-1:0] mb;
      for (int i = 0; i < N_CH; i++) mb[i*BUFF_W +: BUFF_W] = m_buff[i];
      chk("model", 64'({bus.ready, m_rdv ? bus.rdata : 32'd0, pd, ota, buff}),
                   64'({m_ready, m_rdv ? m_rdata : 32'd0, m_pd, m_ota, mb}));
`ifdef MIXER_CTRL_IRQ_EN
      chk("irq", 64'(irq), 64'(m_done && m_irq_en));
`endif
   endtask
   task automatic step(input logic v, input logic w, input logic [1:0] a, input logic [31:0] d);
      bus.valid = v; bus.wstrb = w; bus.address = a; bus.wdata = d;
      @(posedge clk);
      model_edge(v, w, a, d);
      #1;
      cmp_model();
   endtask
   task automatic do_reset();
      @(negedge clk);
      bus.valid = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      cmp_model();
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      int n;
      logic v, w;
      logic [1:0] a;
      logic [31:0] d;
      bus.valid = 1'b0; bus.wstrb = 1'b0; bus.address = '0; bus.wdata = '0;
      tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[1]  = '{1'b1, 1'b0, 2'd1, 32'd0, 1'b1, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[2]  = '{1'b1, 1'b0, 2'd2, 32'd0, 1'b1, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[3]  = '{1'b1, 1'b0, 2'd3, 32'd0, 1'b1, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[4]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[5]  = '{1'b1, 1'b1, 2'd2, 32'd3, 1'b1, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[6]  = '{1'b1, 1'b1, 2'd1, 32'd2, 1'b1, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[7]  = '{1'b1, 1'b1, 2'd0, 32'd1, 1'b1, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b11, 2'b00, 4'h0};
      tbl[9]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b00, 4'h0};
      tbl[10] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b00, 4'h0};
      tbl[11] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b00, 4'h0};
      tbl[12] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b00, 4'h0};
      tbl[13] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b01, 4'h0};
      tbl[14] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b01, 4'h0};
      tbl[15] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b01, 4'h0};
      tbl[16] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b01, 4'h0};
      tbl[17] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 2'b10, 2'b01, 4'h2};
      tbl[18] = '{1'b1, 1'b0, 2'd3, 32'd0, 1'b1, 32'h6, 2'b10, 2'b01, 4'h2};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({pd, ota, buff}), 64'({2'b11, 2'b00, 4'h0}));
      chk("reset_bus", 64'({bus.ready, bus.rdata}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
         chk($sformatf("tbl%0d_out", i), 64'({bus.ready, pd, ota, buff}),
             64'({tbl[i].rdy, tbl[i].pd, tbl[i].ota, tbl[i].buff}));
         if (tbl[i].v && !tbl[i].w) chk($sformatf("tbl%0d_rdata", i), 64'(bus.rdata), 64'(tbl[i].rd));
      end
      // swap ch0 -> ch1 with zero settle; STATUS write lands on the completing edge
      step(1'b1, 1'b1, 2'd3, 32'd0);
      step(1'b1, 1'b1, 2'd2, 32'd0);
      step(1'b1, 1'b1, 2'd0, 32'd2);
      step(1'b0, 1'b0, 2'd0, 32'd0);
      step(1'b0, 1'b0, 2'd0, 32'd0);
      chk("swap_step1", 64'({pd, ota, buff}), 64'({2'b00, 2'b01, 4'h0}));
      step(1'b0, 1'b0, 2'd0, 32'd0);
      chk("swap_step2", 64'({pd, ota, buff}), 64'({2'b00, 2'b10, 4'h0}));
      step(1'b1, 1'b1, 2'd3, 32'd0);
      chk("swap_step3", 64'({pd, ota, buff}), 64'({2'b01, 2'b10, 4'h8}));
      step(1'b1, 1'b0, 2'd3, 32'd0);
      chk("swap_status_done_wins", 64'(bus.rdata), 64'h0a);
      // asynchronous reset during the second wait
      step(1'b1, 1'b1, 2'd2, 32'd5);
      step(1'b1, 1'b1, 2'd0, 32'd3);
      repeat (9) step(1'b0, 1'b0, 2'd0, 32'd0);
      chk("pre_reset_ota", 64'(ota), 64'(2'b11));
      #3 rst = 1'b1;
      #1;
      chk("async_reset_out", 64'({bus.ready, pd, ota, buff}), 64'({1'b0, 2'b11, 2'b00, 4'h0}));
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 2'd3, 32'd0);
      chk("post_reset_status", 64'(bus.rdata), 64'd0);
      // CTRL=11 written while ch0 power-up is waiting
      step(1'b1, 1'b1, 2'd2, 32'd2);
      step(1'b1, 1'b1, 2'd1, 32'd1);
      step(1'b1, 1'b1, 2'd0, 32'd1);
      step(1'b0, 1'b0, 2'd0, 32'd0);
      step(1'b0, 1'b0, 2'd0, 32'd0);
      step(1'b1, 1'b1, 2'd0, 32'd3);
      repeat (15) step(1'b0, 1'b0, 2'd0, 32'd0);
      step(1'b1, 1'b0, 2'd3, 32'd0);
      chk("requeue_status", 64'(bus.rdata), 64'h0e);
      chk("requeue_out", 64'({pd, ota, buff}), 64'({2'b00, 2'b11, 4'h5}));
      // buff code change tracks enabled channels two edges later
      step(1'b1, 1'b1, 2'd1, 32'd3);
      step(1'b0, 1'b0, 2'd0, 32'd0);
      chk("buff_track_1", 64'(buff), 64'h5);
      step(1'b0, 1'b0, 2'd0, 32'd0);
      chk("buff_track_2", 64'(buff), 64'hf);
      step(1'b1, 1'b0, 2'd3, 32'd0);
      chk("buff_track_idle", 64'(bus.rdata), 64'h0e);
      // maximum settle spacing
      do_reset();
      step(1'b1, 1'b1, 2'd2, 32'd255);
      step(1'b1, 1'b1, 2'd0, 32'd1);
      n = 0;
      while (pd[0] && n < 10) begin step(1'b0, 1'b0, 2'd0, 32'd0); n++; end
      chk("ctrl_to_pd_edges", 64'(n), 64'd2);
      n = 0;
      while (!ota[0] && n < 400) begin step(1'b0, 1'b0, 2'd0, 32'd0); n++; end
      chk("max_settle_spacing", 64'(n), 64'd256);
      // random traffic; SETTLE is only rewritten while the sequencer is idle
      do_reset();
      for (int t = 0; t < 4000; t++) begin
         v = $urandom_range(0, 3) != 0;
         w = 1'($urandom_range(0, 1));
         a = 2'($urandom_range(0, 3));
         d = $urandom;
         if (a == 2'd2 && w) begin
            if (m_k >= 0) w = 1'b0;
            else d = 32'($urandom_range(0, 4));
         end
         step(v, w, a, d);
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
